// File: rtl/ps2_host_transmitter_pkg.sv
// Shared PS/2 host definitions: transmitter state encoding, command
// constants and small helpers for timing and frame construction.
package ps2_host_transmitter_pkg;

  typedef logic [2:0] ps2_tx_state_t;

  localparam ps2_tx_state_t ST_IDLE      = 3'd0;
  localparam ps2_tx_state_t ST_INHIBIT   = 3'd1;
  localparam ps2_tx_state_t ST_RELEASE   = 3'd2;
  localparam ps2_tx_state_t ST_SHIFT     = 3'd3;
  localparam ps2_tx_state_t ST_ACK       = 3'd4;
  localparam ps2_tx_state_t ST_WAIT_IDLE = 3'd5;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  // Whole-MHz clock times microseconds gives a cycle count.
  function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
    return (clk_hz / 32'd1000000) * us;
  endfunction

  // PS/2 uses odd parity: the bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Frame as shifted out LSB first: data, parity, stop.
  function automatic logic [9:0] build_frame(input logic [7:0] data);
    return {1'b1, odd_parity(data), data};
  endfunction

endpackage

// File: rtl/ps2_host_transmitter_line_filter.sv
// Conditions one raw PS/2 line: two-flop synchronizer, a run-length
// glitch filter and a one-cycle falling-edge pulse on the filtered level.
// The level resets high, matching an idle bus.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 32'd8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_raw,
  output logic level,
  output logic fall
);

  logic                  sync1_r;
  logic                  sync2_r;
  logic [FILTER_LEN-1:0] hist_r;
  logic                  level_r;
  logic                  fall_r;

  // Synchronize, keep the last FILTER_LEN samples, accept a level only when all agree.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      hist_r  <= {FILTER_LEN{1'b1}};
      level_r <= 1'b1;
      fall_r  <= 1'b0;
    end else begin
      sync1_r <= line_raw;
      sync2_r <= sync1_r;
      hist_r  <= {hist_r[FILTER_LEN-2:0], sync2_r};
      if (&hist_r) begin
        level_r <= 1'b1;
        fall_r  <= 1'b0;
      end else if (~|hist_r) begin
        level_r <= 1'b0;
        fall_r  <= level_r;
      end else begin
        fall_r  <= 1'b0;
      end
    end
  end

  assign level = level_r;
  assign fall  = fall_r;

endmodule

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a
// request-to-send, shifts one command byte out on device clock edges,
// checks the device ACK and reports done or error. txBusy doubles as
// the receive-path inhibit.
module ps2_host_transmitter
  import ps2_host_transmitter_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 32'd100000000,
  parameter int unsigned INHIBIT_US      = 32'd100,
  parameter int unsigned TIMEOUT_US      = 32'd20000,
  parameter int unsigned FILTER_LEN      = 32'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txStart,
  input  logic [7:0] txData,
  output logic       txBusy,
  output logic       txDone,
  output logic       txError,
  output logic       rxInhibit,
  input  logic       ps2ClkIn,
  input  logic       ps2DataIn,
  output logic       ps2ClkDriveLow,
  output logic       ps2DataDriveLow
);

  localparam int unsigned INHIBIT_CYCLES = us_to_cycles(CLOCK_FREQUENCY, INHIBIT_US);
  localparam int unsigned TIMEOUT_CYCLES = us_to_cycles(CLOCK_FREQUENCY, TIMEOUT_US);

  logic          clk_level_s;
  logic          clk_fall_s;
  logic          data_level_s;
  logic          data_fall_unused_s;

  ps2_tx_state_t state_r;
  logic [9:0]    bits_r;
  logic [3:0]    bit_cnt_r;
  logic [31:0]   inhibit_cnt_r;
  logic [31:0]   timer_r;
  logic          tx_busy_r;
  logic          tx_done_r;
  logic          tx_error_r;
  logic          clk_drive_r;
  logic          data_drive_r;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk      (clk),
    .rst      (rst),
    .line_raw (ps2ClkIn),
    .level    (clk_level_s),
    .fall     (clk_fall_s)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk      (clk),
    .rst      (rst),
    .line_raw (ps2DataIn),
    .level    (data_level_s),
    .fall     (data_fall_unused_s)
  );

  // Transfer sequencer: all outputs come straight from these registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      bits_r        <= 10'd0;
      bit_cnt_r     <= 4'd0;
      inhibit_cnt_r <= 32'd0;
      timer_r       <= 32'd0;
      tx_busy_r     <= 1'b0;
      tx_done_r     <= 1'b0;
      tx_error_r    <= 1'b0;
      clk_drive_r   <= 1'b0;
      data_drive_r  <= 1'b0;
    end else begin
      tx_done_r  <= 1'b0;
      tx_error_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (txStart) begin
            bits_r        <= build_frame(txData);
            bit_cnt_r     <= 4'd0;
            inhibit_cnt_r <= 32'd0;
            tx_busy_r     <= 1'b1;
            clk_drive_r   <= 1'b1;
            data_drive_r  <= 1'b0;
            state_r       <= ST_INHIBIT;
          end else begin
            state_r       <= ST_IDLE;
          end
        end
        ST_INHIBIT: begin
          // The host owns the clock here, so the sampled clock is ignored.
          if (inhibit_cnt_r == INHIBIT_CYCLES - 32'd1) begin
            clk_drive_r  <= 1'b0;
            data_drive_r <= 1'b1;
            timer_r      <= 32'd0;
            state_r      <= ST_RELEASE;
          end else begin
            inhibit_cnt_r <= inhibit_cnt_r + 32'd1;
          end
        end
        ST_RELEASE, ST_SHIFT, ST_ACK, ST_WAIT_IDLE: begin
          if (timer_r == TIMEOUT_CYCLES - 32'd1) begin
            // Device stopped responding: give the bus back and report.
            tx_error_r   <= 1'b1;
            tx_busy_r    <= 1'b0;
            clk_drive_r  <= 1'b0;
            data_drive_r <= 1'b0;
            state_r      <= ST_IDLE;
          end else begin
            timer_r <= timer_r + 32'd1;
            case (state_r)
              ST_RELEASE: begin
                state_r <= ST_SHIFT;
              end
              ST_SHIFT: begin
                if (clk_fall_s) begin
                  // Stop bit is 1, so the tenth edge releases the data line.
                  data_drive_r <= ~bits_r[0];
                  bits_r       <= {1'b0, bits_r[9:1]};
                  bit_cnt_r    <= bit_cnt_r + 4'd1;
                  if (bit_cnt_r == 4'd9) begin
                    state_r <= ST_ACK;
                  end else begin
                    state_r <= ST_SHIFT;
                  end
                end else begin
                  state_r <= ST_SHIFT;
                end
              end
              ST_ACK: begin
                if (clk_fall_s) begin
                  if (!data_level_s) begin
                    state_r <= ST_WAIT_IDLE;
                  end else begin
                    tx_error_r   <= 1'b1;
                    tx_busy_r    <= 1'b0;
                    clk_drive_r  <= 1'b0;
                    data_drive_r <= 1'b0;
                    state_r      <= ST_IDLE;
                  end
                end else begin
                  state_r <= ST_ACK;
                end
              end
              ST_WAIT_IDLE: begin
                if (clk_level_s && data_level_s) begin
                  tx_done_r <= 1'b1;
                  tx_busy_r <= 1'b0;
                  state_r   <= ST_IDLE;
                end else begin
                  state_r   <= ST_WAIT_IDLE;
                end
              end
              default: begin
                state_r <= ST_IDLE;
              end
            endcase
          end
        end
        default: begin
          tx_busy_r    <= 1'b0;
          clk_drive_r  <= 1'b0;
          data_drive_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign txBusy          = tx_busy_r;
  assign rxInhibit       = tx_busy_r;
  assign txDone          = tx_done_r;
  assign txError         = tx_error_r;
  assign ps2ClkDriveLow  = clk_drive_r;
  assign ps2DataDriveLow = data_drive_r;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: an open-drain bus with a behavioural
// keyboard that clocks the frame, samples each bit against a queue of
// expected levels and optionally ACKs; a monitor pops expected outcomes.
module tb_ps2_host_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       txStart = 1'b0;
  logic [7:0] txData = 8'h00;
  logic       txBusy, txDone, txError, rxInhibit;
  logic       ps2ClkIn, ps2DataIn, ps2ClkDriveLow, ps2DataDriveLow;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic       bit_q[$];
  logic [1:0] evt_q[$];
  logic [1:0] mon_exp;

  assign ps2ClkIn  = ~(ps2ClkDriveLow | dev_clk_low);
  assign ps2DataIn = ~(ps2DataDriveLow | dev_data_low);

  ps2_host_transmitter #(
    .CLOCK_FREQUENCY(32'd1000000),
    .INHIBIT_US     (32'd100),
    .TIMEOUT_US     (32'd20000),
    .FILTER_LEN     (32'd4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .txStart        (txStart),
    .txData         (txData),
    .txBusy         (txBusy),
    .txDone         (txDone),
    .txError        (txError),
    .rxInhibit      (rxInhibit),
    .ps2ClkIn       (ps2ClkIn),
    .ps2DataIn      (ps2DataIn),
    .ps2ClkDriveLow (ps2ClkDriveLow),
    .ps2DataDriveLow(ps2DataDriveLow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every done/error pulse must match the next expected outcome.
  always @(negedge clk) begin
    if (rst && (txDone || txError)) begin
      check("done_err_excl", 32'(txDone & txError), 32'd0);
      if (evt_q.size() == 0) begin
        check("unexpected_evt", 32'({txDone, txError}), 32'd0);
      end else begin
        mon_exp = evt_q.pop_front();
        check("evt", 32'({txDone, txError}), 32'(mon_exp));
        check("busy_at_evt", 32'({txBusy, rxInhibit}), 32'd0);
      end
    end
  end

  task automatic start_tx(input logic [7:0] d, input int n_bits, input logic [1:0] evt);
    int   ones;
    logic par;
    ones = 0;
    for (int b = 0; b < 8; b++) ones += int'(d[b]);
    par = ((ones % 2) == 0);
    for (int b = 0; b < n_bits; b++)
      bit_q.push_back(b < 8 ? d[b] : (b == 8 ? par : 1'b1));
    if (evt != 2'b00) evt_q.push_back(evt);
    @(negedge clk);
    txStart = 1'b1;
    txData  = d;
    @(negedge clk);
    txStart = 1'b0;
    txData  = 8'h00;
    check("busy_after_start", 32'({txBusy, rxInhibit}), 32'd3);
  endtask

  task automatic wait_release();
    int n;
    n = 0;
    while (ps2ClkDriveLow === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("inhibit_len", 32'(n), 32'd100);
    check("start_bit", 32'(ps2DataDriveLow), 32'd1);
  endtask

  task automatic device_run(input logic ack_low, input int n_fall);
    logic e;
    wait_release();
    repeat (20) @(negedge clk);
    for (int i = 0; i < n_fall; i++) begin
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (10) @(negedge clk);
      if (i < 10) begin
        if (bit_q.size() == 0) begin
          check("bit_q_empty", 32'd1, 32'd0);
        end else begin
          e = bit_q.pop_front();
          check($sformatf("bit%0d", i), 32'(ps2DataIn), 32'(e));
        end
      end
      if (i == 9 && ack_low) dev_data_low = 1'b1;
      if (i == 10) dev_data_low = 1'b0;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (txBusy === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("busy_cleared", 32'(txBusy), 32'd0);
    repeat (5) @(negedge clk);
    check("evt_pending", 32'(evt_q.size()), 32'd0);
    check("bits_pending", 32'(bit_q.size()), 32'd0);
  endtask

  initial begin
    int t0;
    int k;
    repeat (5) @(negedge clk);
    check("reset_outputs",
          32'({txBusy, txDone, txError, rxInhibit, ps2ClkDriveLow, ps2DataDriveLow}), 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // Set-LEDs command with ACK.
    start_tx(8'hED, 10, 2'b10);
    device_run(1'b1, 11);
    wait_idle();

    // Parity extremes.
    start_tx(8'h00, 10, 2'b10);
    device_run(1'b1, 11);
    wait_idle();
    start_tx(8'h01, 10, 2'b10);
    device_run(1'b1, 11);
    wait_idle();

    // Device never clocks: timeout after release.
    start_tx(8'hA5, 0, 2'b01);
    wait_release();
    t0 = cyc;
    k = 0;
    while (txError !== 1'b1 && k < 25000) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycles", 32'(cyc - t0), 32'd20000);
    check("timeout_lines", 32'({ps2ClkDriveLow, ps2DataDriveLow, txBusy}), 32'd0);
    wait_idle();

    // Missing ACK, then a new transfer must be accepted.
    start_tx(8'h5A, 10, 2'b01);
    device_run(1'b0, 11);
    wait_idle();
    start_tx(8'hFF, 10, 2'b10);
    device_run(1'b1, 11);
    wait_idle();

    // Second start during SHIFT is dropped.
    start_tx(8'hED, 10, 2'b10);
    fork
      device_run(1'b1, 11);
      begin
        repeat (250) @(negedge clk);
        txStart = 1'b1;
        txData  = 8'hFF;
        @(negedge clk);
        txStart = 1'b0;
        txData  = 8'h00;
        check("busy_during_shift", 32'(txBusy), 32'd1);
      end
    join
    wait_idle();
    repeat (30) @(negedge clk);
    check("no_queued_start", 32'({txBusy, ps2ClkDriveLow}), 32'd0);

    // Reset in the middle of SHIFT.
    start_tx(8'h3C, 5, 2'b00);
    device_run(1'b1, 5);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_shift",
          32'({txBusy, rxInhibit, txDone, txError, ps2ClkDriveLow, ps2DataDriveLow}), 32'd0);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_after_rst", 32'({txBusy, ps2ClkDriveLow, ps2DataDriveLow}), 32'd0);
    check("evt_after_rst", 32'(evt_q.size()), 32'd0);

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_host_transmitter.md
Name: ps2_host_transmitter

Overview:
PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED followed by an LED mask, or 0xFF reset. It is the counterpart of the PS/2 receive path (Ps2StateMachine). It drives the open-drain PS/2 clock and data lines, uses the device-generated clock, checks the device ACK, and holds off the receive path while a transfer is in progress.

Parameters:
CLOCK_FREQUENCY, 100000000, system clock frequency in Hz.
INHIBIT_US, 100, time the host holds the clock line low before the request-to-send.
TIMEOUT_US, 20000, maximum time from clock release to ACK completion.
FILTER_LEN, 8, number of consecutive equal samples needed to accept a line level.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-low reset.
txStart  in  1  one-cycle request; accepted only when txBusy=0.
txData  in  8  command byte; captured in the cycle txStart is accepted.
txBusy  out  1  high from the cycle after acceptance until the return to IDLE.
txDone  out  1  one-cycle pulse: byte sent and ACK received.
txError  out  1  one-cycle pulse: timeout or missing ACK.
rxInhibit  out  1  equals txBusy; the receiver ignores frames while it is high.
ps2ClkIn  in  1  raw PS/2 clock line level.
ps2DataIn  in  1  raw PS/2 data line level.
ps2ClkDriveLow  out  1  1 = pull the clock line low; 0 = release it.
ps2DataDriveLow  out  1  1 = pull the data line low; 0 = release it.

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0, state IDLE, counters cleared. If reset arrives mid-transfer, both lines are released at that edge. No txDone or txError pulse is issued.
- Line filtering: each raw input passes a 2-FF synchronizer, then a FILTER_LEN-sample filter. A clock falling edge (fallEdge) is a 1-cycle pulse when the filtered clock goes 1->0.
- Cycle constants: inhibitCycles = CLOCK_FREQUENCY/1000000*INHIBIT_US; timeoutCycles is computed the same way from TIMEOUT_US.
- Frame stored at acceptance: bits[9:0] = {stop=1, parity=~^txData, txData[7:0]}, shifted out LSB first.
- IDLE: txStart=1 captures the frame, sets txBusy, moves to INHIBIT. txStart while busy is ignored, with no queueing.
- INHIBIT: ps2ClkDriveLow=1 for inhibitCycles. On the last cycle, ps2DataDriveLow is set to 1 (start bit) and the state moves to RELEASE.
- RELEASE: ps2ClkDriveLow=0 and the timeout timer starts. The state moves to SHIFT on the same cycle.
- SHIFT: on each fallEdge, ps2DataDriveLow = ~bits[0], bits shift right, and bitCnt increments.
  - bitCnt 0..7 are data, 8 is parity, 9 is stop (data released).
  - After the 10th fallEdge, the state moves to ACK.
- ACK: on the next fallEdge, the filtered data is sampled.
  - 0: go to WAIT_IDLE.
  - 1: pulse txError, release both lines, go to IDLE.
- WAIT_IDLE: wait until filtered clock and data are both 1, then pulse txDone, clear txBusy, go to IDLE.
  - txDone and the txBusy fall occur on the same edge.
- Timeout: if the timer reaches timeoutCycles in any of RELEASE, SHIFT, ACK or WAIT_IDLE: pulse txError, release both lines, go to IDLE.
- txDone and txError are mutually exclusive. Neither is ever asserted outside a transfer.
- The device holding the clock low during INHIBIT has no effect; the host owns the line in that state.

Decomposition:
- Ps2Pkg holds:
  - Ps2TxState_t (IDLE, INHIBIT, RELEASE, SHIFT, ACK, WAIT_IDLE);
  - the us-to-cycles function;
  - PS2_CMD_SET_LEDS=8'hED, PS2_CMD_RESET=8'hFF, PS2_ACK=8'hFA.
- Sub-module ps2_line_filter: synchronizer, FILTER_LEN filter and falling-edge pulse. It is instantiated twice, once for clock and once for data, and is shareable with the receive path.

Test Plan:
Bench settings: CLOCK_FREQUENCY=1000000 (inhibitCycles=100), FILTER_LEN=4. The device model generates a clock with a 40 µs period.
1. txStart, txData=8'hED, device ACKs -> ps2ClkDriveLow high for 100 cycles; data bits on successive fallEdges are 1,0,1,1,0,1,1,1; parity 1; stop released; then txDone pulses once and txBusy falls.
2. txData=8'h00 -> parity bit 1 (ps2DataDriveLow=0 at the 9th fallEdge); txData=8'h01 -> parity bit 0.
3. Device never clocks after release, TIMEOUT_US=20000 -> txError pulses at 20000 cycles after RELEASE; both lines released; txBusy=0.
4. Device leaves data high at the ACK edge -> txError pulses once with no txDone; returns to IDLE; a new txStart is accepted.
5. Second txStart during SHIFT with txData=8'hFF -> ignored; the original 0xED completes unchanged.
6. rst=0 in the middle of SHIFT -> at the next edge both drive-lows are 0, txBusy=0, and no txDone or txError pulse appears.
